// File: rtl/instr_mem_slave.sv
// Purpose: instruction fetch responder in front of a synchronous single-port SRAM; flags misaligned/out-of-window fetches.
// Latency: fixed LATENCY cycles from instr_gnt to instr_valid, strictly in order, one response per grant.
// Backpressure: grant withheld while gnt_block is high or MAX_OUTSTANDING responses are pending (unless one retires this cycle).
module instr_mem_slave #(
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter int          MEM_WORDS       = 4096,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_req,
    input  logic [31:0]                  instr_addr,
    output logic                         instr_gnt,
    output logic                         instr_valid,
    output logic [31:0]                  instr_rdata,
    output logic                         instr_err,
    input  logic                         gnt_block,
    output logic                         mem_req,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [31:0]                  mem_rdata
);

    localparam int         AW     = $clog2(MEM_WORDS);
    localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

    logic [2:0]         cnt;
    logic [32:0]        addr_ext;
    logic [32:0]        win_lo;
    logic [32:0]        win_hi;
    logic               addr_err;
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] err_pipe;
    logic [31:0]        rsp_dat;
    logic               out_vld;
    logic               out_err;

    // Window decode in 33 bits so a window touching 4 GiB never wraps.
    always_comb begin
        addr_ext = {1'b0, instr_addr};
        win_lo   = {1'b0, MEM_BASE};
        win_hi   = win_lo + ({1'b0, 32'(MEM_WORDS)} << 2);
        addr_err = (instr_addr[1:0] != 2'b00) | (addr_ext < win_lo) | (addr_ext >= win_hi);
    end

    // Grant admits a new request when a slot is free, or when the last slot frees this very cycle.
    always_comb begin
        out_vld   = vld_pipe[LATENCY-1] & ~reset;
        out_err   = err_pipe[LATENCY-1];
        instr_gnt = instr_req & ~gnt_block & ~reset &
                    ((cnt < MAX_OS) | ((cnt == MAX_OS) & out_vld));
        mem_req   = instr_gnt & ~addr_err;
        mem_addr  = AW'((instr_addr - MEM_BASE) >> 2);
    end

    // Outstanding counter: grants in, responses out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {2'b00, instr_gnt} - {2'b00, out_vld};
        end
    end

    // Valid/error shift register; reset drops every in-flight response.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
            vld_pipe[0] <= instr_gnt;
            err_pipe[0] <= addr_err;
        end
    end

    // SRAM data arrives one cycle after the grant; extra latency stages just delay it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign rsp_dat = mem_rdata;
        end else begin : g_delay
            logic [31:0] dat_pipe [LATENCY-1];

            // Data stages carry no reset: they are only observed when the valid bit is set.
            always_ff @(posedge clk) begin
                dat_pipe[0] <= mem_rdata;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end

            assign rsp_dat = dat_pipe[LATENCY-2];
        end
    endgenerate

    // Response data is forced to zero when idle or on an error response.
    always_comb begin
        instr_valid = out_vld;
        instr_err   = out_vld & out_err;
        instr_rdata = (out_vld & ~out_err) ? rsp_dat : 32'h0;
    end

endmodule

// File: tb/tb_instr_mem_slave.sv
// Purpose: randomized + directed check of instr_mem_slave in four latency/outstanding configurations.
// Latency: per-cycle grant prediction; responses scoreboarded against their due cycle.
// Backpressure: gnt_block and outstanding limit exercised by random stimulus.
module tb_instr_mem_slave;

    localparam int NCFG  = 4;
    localparam int W     = 64;
    localparam int N_DIR = 30;
    localparam int N_RND = 3000;

    typedef struct {
        int          due;
        logic [31:0] dat;
        bit          err;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic all_fin;

    always #5 clk = ~clk;

    // Cycle index advances on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s cyc=%0d: got %h expected %h", g, nm, cyc, act, exp);
    endtask

    // Directed prefix: {rst, req, blk, offset-from-base}.
    function automatic logic [34:0] dir_stim(input int c, input int w);
        logic [31:0] top;
        top = 32'(4 * w);
        case (c)
            0:          return {3'b010, 32'h0};
            4, 5, 6:    return {3'b010, 32'((c - 4) * 4)};
            10:         return {3'b010, 32'h2};
            11:         return {3'b010, top};
            12:         return {3'b010, top - 32'h4};
            13:         return {3'b010, 32'hFFFF_FFFC};
            16:         return {3'b010, 32'd12};
            17, 18, 19: return {3'b011, 32'd16};
            20:         return {3'b010, 32'd16};
            22:         return {3'b010, 32'd20};
            23:         return {3'b100, 32'h0};
            25:         return {3'b010, 32'd24};
            default:    return '0;
        endcase
    endfunction

    function automatic logic [34:0] rnd_stim(input int w);
        logic [31:0] off;
        logic        r, q, b;
        case ($urandom_range(0, 9))
            0:       off = 32'(4 * w);
            1:       off = 32'hFFFF_FFFC;
            2:       off = 32'($urandom_range(0, 4 * w - 1));
            3:       off = $urandom;
            default: off = 32'(4 * $urandom_range(0, w - 1));
        endcase
        r = ($urandom_range(0, 199) == 0);
        q = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 5) == 0);
        return {r, q, b, off};
    endfunction

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_cfg
            localparam int          L    = (g == 0) ? 1 : (g == 3) ? 4 : 2;
            localparam int          MO   = (g == 2) ? 1 : (g == 3) ? 3 : 2;
            localparam logic [31:0] BASE = (g == 1) ? 32'h1000 : (g == 2) ? 32'h200 : 32'h0;

            logic        rst, req, blk;
            logic [31:0] addr;
            logic        gnt, vld, err, mreq;
            logic [31:0] rdata;
            logic [5:0]  maddr;
            logic [31:0] mrdata;
            logic [31:0] mem [W];
            bit          armed = 1'b0;
            bit          fin = 1'b0;
            rsp_t        exp_q [$];

            rsp_t        r;
            bit          exp_v;
            logic [34:0] s;
            logic [32:0] a33;
            int          n;
            bit          due_now, eg, ee;

            instr_mem_slave #(
                .MEM_BASE(BASE),
                .MEM_WORDS(W),
                .LATENCY(L),
                .MAX_OUTSTANDING(MO)
            ) dut (
                .clk(clk),
                .reset(rst),
                .instr_req(req),
                .instr_addr(addr),
                .instr_gnt(gnt),
                .instr_valid(vld),
                .instr_rdata(rdata),
                .instr_err(err),
                .gnt_block(blk),
                .mem_req(mreq),
                .mem_addr(maddr),
                .mem_rdata(mrdata)
            );

            // Synchronous SRAM: read data one cycle after the enable.
            always @(posedge clk) if (mreq === 1'b1) mrdata <= mem[maddr];

            // Driver and reference model: predicts grant and enqueues the response it owes.
            initial begin : drv
                rst = 1'b1; req = 1'b0; blk = 1'b0; addr = '0;
                for (int i = 0; i < W; i++) mem[i] = $urandom;
                mem[0] = 32'h0000_0013;
                repeat (3) @(posedge clk);
                #1;
                armed = 1'b1;
                for (int c = 0; c < N_DIR + N_RND + 12; c++) begin
                    if (c < N_DIR) s = dir_stim(c, W);
                    else if (c < N_DIR + N_RND) s = rnd_stim(W);
                    else s = '0;
                    rst  = s[34];
                    req  = s[33];
                    blk  = s[32];
                    addr = BASE + s[31:0];
                    @(negedge clk);
                    if (rst) begin
                        chk("rst_gnt", g, 32'(gnt), 0);
                        chk("rst_valid", g, 32'(vld), 0);
                        chk("rst_rdata", g, rdata, 0);
                        chk("rst_err", g, 32'(err), 0);
                        chk("rst_mem_req", g, 32'(mreq), 0);
                        exp_q.delete();
                    end else begin
                        n       = exp_q.size();
                        due_now = (n > 0) && (exp_q[0].due == cyc);
                        eg      = req && !blk && ((n < MO) || (n == MO && due_now));
                        a33     = {1'b0, addr};
                        ee      = (addr % 4 != 0) || (a33 < {1'b0, BASE}) ||
                                  (a33 >= {1'b0, BASE} + 33'(4 * W));
                        chk("instr_gnt", g, 32'(gnt), 32'(eg));
                        chk("mem_req", g, 32'(mreq), 32'(eg && !ee));
                        if (eg && !ee) chk("mem_addr", g, 32'(maddr), (addr - BASE) / 4);
                        if (eg) exp_q.push_back('{due: cyc + L,
                                                  dat: ee ? 32'h0 : mem[(addr - BASE) / 4],
                                                  err: ee});
                    end
                    @(posedge clk);
                    #1;
                end
                chk("drained", g, 32'(exp_q.size()), 0);
                fin = 1'b1;
            end

            // Monitor: retires the oldest expected response when it falls due.
            always @(negedge clk) begin
                if (armed && !rst) begin
                    #2;
                    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                    chk("instr_valid", g, 32'(vld), 32'(exp_v));
                    if (exp_v) begin
                        r = exp_q.pop_front();
                        chk("instr_rdata", g, rdata, r.dat);
                        chk("instr_err", g, 32'(err), 32'(r.err));
                    end else if (vld !== 1'b1) begin
                        chk("idle_rdata", g, rdata, 32'h0);
                    end
                end
            end
        end
    endgenerate

    assign all_fin = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin;

    // Bounded wait for all configurations, then report.
    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (all_fin) break;
        end
        chk("completion", -1, 32'(all_fin), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
